// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, a running accumulator
// and a registered zero flag. S1 holds the operands, S2 holds the result.
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   c,
  output logic             out_zero
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_ACC  = 3'b110;
  localparam logic [2:0] OP_ACLR = 3'b111;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   result;
  logic             stall;
  logic             advance;

  // The whole pipe moves as one unit; an empty S2 never blocks S1.
  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  always_comb begin
    a_ext    = {1'b0, s1_a};
    b_ext    = {1'b0, s1_b};
    acc_next = acc;
    result   = '0;
    case (s1_op)
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_AND:  result = a_ext & b_ext;
      OP_OR:   result = a_ext | b_ext;
      OP_XOR:  result = a_ext ^ b_ext;
      OP_SHL:  result = a_ext << s1_b[SHW-1:0];
      OP_ACC: begin
        acc_next = acc + a_ext;
        result   = acc_next;
      end
      OP_ACLR: begin
        acc_next = '0;
        result   = '0;
      end
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      out_valid <= 1'b0;
      c         <= '0;
      out_zero  <= 1'b0;
      acc       <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op_code;
      end
      out_valid <= s1_valid;
      // Accumulator only commits when its beat actually enters S2.
      if (s1_valid) begin
        c        <= result;
        out_zero <= (result == '0);
        acc      <= acc_next;
      end else begin
        out_zero <= 1'b0;
      end
    end
  end

endmodule
